// File: rtl/uart_pkg.sv
// Shared UART transmit types, framing constants and packet builder.
// Packet layout, bit 0 first: start, data LSB-first, even parity, stop.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_PACKET_W   = UART_DATA_W + 3;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        SEND
    } tx_state_t;

    function automatic logic [UART_PACKET_W-1:0] build_packet(input logic [UART_DATA_W-1:0] data);
        return {STOP_BIT, ^data, data, START_BIT};
    endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Purpose: counts sample-enable ticks within one transmitted bit, flags the bit's last tick.
// Latency: bit_end is combinational from the registered count; the count updates one edge after a tick.
// Backpressure: none; ticks are consumed only while run is high, clr/reset dominate start.
module tx_bit_timer #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic start,
    input  logic run,
    input  logic tick,
    output logic bit_end
);

    localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(OVERSAMPLE);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [CNT_W-1:0] tick_cnt;

    // The tick that opens a bit counts as tick 1, so a bit spans exactly OVERSAMPLE ticks.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            tick_cnt <= '0;
        end else if (start) begin
            tick_cnt <= ONE_CNT;
        end else if (run && tick) begin
            tick_cnt <= bit_end ? ONE_CNT : tick_cnt + 1'b1;
        end
    end

    assign bit_end = (tick_cnt == TERM_CNT);

endmodule

// File: rtl/uart_tx_data_transmission.sv
// Purpose: frames a byte (start, data LSB-first, even parity, stop) and serialises it on TxD; option UART_TX_HOLD_BUFFER_EN.
// Latency: Tx_BUSY one edge after accept; start bit on the first sample tick after that; each bit lasts OVERSAMPLE ticks.
// Backpressure: Tx_WR is dropped while Tx_BUSY (or, with the hold buffer, while the hold entry is full).
module uart_tx_data_transmission
    import uart_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int PACKET_W   = DATA_W + 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Tx_EN,
    input  logic              Tx_sample_ENABLE,
    input  logic              Tx_WR,
    input  logic [DATA_W-1:0] Tx_DATA,
    output logic              TxD,
    output logic              Tx_BUSY,
    output logic              Tx_DONE
);

    localparam int BI_W = $clog2(PACKET_W);
    localparam logic [BI_W-1:0] LAST_IDX = BI_W'(PACKET_W - 1);

    tx_state_t           state_q;
    tx_state_t           state_nxt;
    logic [PACKET_W-1:0] sh_q;
    logic [BI_W-1:0]     bit_idx_q;
    logic                txd_q;
    logic                done_q;

    logic                bit_end;
    logic                abort;
    logic                accept;
    logic                first_tick;
    logic                bit_tick;
    logic                last_tick;
    logic                timer_clr;
    logic [PACKET_W-1:0] pkt_new;
    logic                next_vld;
    logic [PACKET_W-1:0] next_pkt;

    assign pkt_new    = build_packet(Tx_DATA);
    assign abort      = !Tx_EN;
    assign accept     = Tx_WR && Tx_EN && (state_q == IDLE);
    assign first_tick = (state_q == WAIT_TICK) && Tx_sample_ENABLE;
    assign bit_tick   = (state_q == SEND) && Tx_sample_ENABLE && bit_end;
    assign last_tick  = bit_tick && (bit_idx_q == LAST_IDX);

`ifdef UART_TX_HOLD_BUFFER_EN
    logic                hold_vld_q;
    logic [PACKET_W-1:0] hold_q;
    logic                hold_wr;

    assign hold_wr  = Tx_WR && Tx_EN && (state_q != IDLE) && !hold_vld_q;
    // A write landing on the stop bit's last tick chains straight through without parking.
    assign next_vld = hold_vld_q || hold_wr;
    assign next_pkt = hold_vld_q ? hold_q : pkt_new;

    always_ff @(posedge clk) begin
        if (reset || abort) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (last_tick && next_vld) begin
            hold_vld_q <= 1'b0;
        end else if (hold_wr) begin
            hold_vld_q <= 1'b1;
            hold_q     <= pkt_new;
        end
    end
`else
    assign next_vld = 1'b0;
    assign next_pkt = '0;
`endif

    assign timer_clr = abort || (last_tick && !next_vld);

    tx_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (timer_clr),
        .start   (first_tick),
        .run     (state_q == SEND),
        .tick    (Tx_sample_ENABLE),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state_q)
                IDLE:      if (accept) state_nxt = WAIT_TICK;
                WAIT_TICK: if (Tx_sample_ENABLE) state_nxt = SEND;
                SEND:      if (last_tick && !next_vld) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Shift register keeps the bit on the line in sh_q[0]; TxD is registered so it only moves on ticks.
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            sh_q      <= '0;
            bit_idx_q <= '0;
            txd_q     <= STOP_BIT;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_tick;
            if (accept) begin
                sh_q      <= pkt_new;
                bit_idx_q <= '0;
            end else if (first_tick) begin
                txd_q <= sh_q[0];
            end else if (last_tick) begin
                bit_idx_q <= '0;
                if (next_vld) begin
                    sh_q  <= next_pkt;
                    txd_q <= next_pkt[0];
                end else begin
                    sh_q  <= '0;
                    txd_q <= STOP_BIT;
                end
            end else if (bit_tick) begin
                sh_q      <= sh_q >> 1;
                bit_idx_q <= bit_idx_q + 1'b1;
                txd_q     <= sh_q[1];
            end
        end
    end

    always_comb begin
        TxD     = txd_q;
        Tx_BUSY = (state_q != IDLE);
        Tx_DONE = done_q;
    end

endmodule

// File: tb/tb_uart_tx_data_transmission.sv
// Scoreboard bench: expected 11-bit frames are queued at write time; a 16x model receiver rebuilds frames and checks them on Tx_DONE.
module tb_uart_tx_data_transmission;

    logic       clk;
    logic       reset;
    logic       Tx_EN;
    logic       Tx_sample_ENABLE;
    logic       Tx_WR;
    logic [7:0] Tx_DATA;
    logic       TxD;
    logic       Tx_BUSY;
    logic       Tx_DONE;

    uart_tx_data_transmission dut (
        .clk              (clk),
        .reset            (reset),
        .Tx_EN            (Tx_EN),
        .Tx_sample_ENABLE (Tx_sample_ENABLE),
        .Tx_WR            (Tx_WR),
        .Tx_DATA          (Tx_DATA),
        .TxD              (TxD),
        .Tx_BUSY          (Tx_BUSY),
        .Tx_DONE          (Tx_DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames written bit10..bit0 = {stop, parity, data, start}, parity worked out by hand.
    localparam logic [10:0] FR_A5 = 11'b1_0_10100101_0;
    localparam logic [10:0] FR_07 = 11'b1_1_00000111_0;
    localparam logic [10:0] FR_55 = 11'b1_0_01010101_0;
    localparam logic [10:0] FR_3C = 11'b1_0_00111100_0;
    localparam logic [10:0] FR_11 = 11'b1_0_00010001_0;
    localparam logic [10:0] FR_22 = 11'b1_0_00100010_0;

    logic [10:0] exp_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int n_done_exp  = 0;

    int          tick_no = 0;
    int          done_cnt = 0;
    int          rx_starts = 0;
    int          last_done_tick = 0;
    int          prev_done_tick = 0;
    bit          rx_active = 0;
    int          rx_cnt = 0;
    logic [10:0] rx_word = '0;
    bit          rx_bad = 0;
    bit          rx_ended = 0;
    logic [10:0] end_word = '0;
    bit          end_bad = 0;
    bit          mon_tk;
    logic [10:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // 16x tick every 4 clocks, driven away from the active edge.
    initial begin
        int div;
        div = 0;
        Tx_sample_ENABLE = 1'b0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            Tx_sample_ENABLE = (div == 0);
        end
    end

    // Model receiver + scoreboard monitor.
    always @(posedge clk) begin
        mon_tk = (Tx_sample_ENABLE === 1'b1);
        #1;
        rx_ended = 0;
        if (rx_active && Tx_BUSY === 1'b0 && Tx_DONE !== 1'b1)
            rx_active = 0;
        if (mon_tk) begin
            tick_no++;
            if (rx_active) begin
                rx_cnt++;
                if (rx_cnt == 177) begin
                    rx_active = 0;
                    rx_ended  = 1;
                    end_word  = rx_word;
                    end_bad   = rx_bad;
                end else if ((rx_cnt - 1) % 16 == 0) begin
                    rx_word[(rx_cnt - 1) / 16] = TxD;
                end else if (TxD !== rx_word[(rx_cnt - 1) / 16]) begin
                    rx_bad = 1;
                end
                if (rx_active && Tx_BUSY !== 1'b1) rx_bad = 1;
            end
            if (!rx_active && TxD === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 1;
                rx_word   = '0;
                rx_bad    = 0;
                rx_starts++;
            end
        end else if (rx_active && TxD !== rx_word[(rx_cnt - 1) / 16]) begin
            rx_bad = 1;
        end

        if (Tx_DONE === 1'b1) begin
            done_cnt++;
            prev_done_tick = last_done_tick;
            last_done_tick = tick_no;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got frame %b, want no Tx_DONE", end_word);
            end else begin
                mon_exp = exp_q.pop_front();
                check("frame_duration_176_ticks", 32'(rx_ended), 32'd1);
                check("frame_word", 32'(end_word), 32'(mon_exp));
                check("bit_hold_and_busy", 32'(end_bad), 32'd0);
            end
        end else if (rx_ended) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_done: got frame %b without Tx_DONE, want a pulse", end_word);
        end
    end

    task automatic do_write(input logic [7:0] d);
        @(negedge clk);
        Tx_WR   = 1'b1;
        Tx_DATA = d;
        @(negedge clk);
        Tx_WR   = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [10:0] frame);
        exp_q.push_back(frame);
        n_done_exp++;
        do_write(d);
    endtask

    task automatic wait_done(input int n);
        int c;
        c = 0;
        while (done_cnt < n && c < 4000) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt < n) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done_timeout: got %0d pulses, want %0d", done_cnt, n);
        end
    endtask

    task automatic wait_frame_tick(input int n);
        int c;
        c = 0;
        while (!(rx_active && rx_cnt >= n) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (!(rx_active && rx_cnt >= n)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick_timeout: got tick %0d, want %0d", rx_cnt, n);
        end
    endtask

    initial begin
        int d0;
        int s0;
        reset   = 1'b1;
        Tx_EN   = 1'b1;
        Tx_WR   = 1'b0;
        Tx_DATA = '0;
        repeat (3) @(negedge clk);
        check("reset_txd", 32'(TxD), 32'd1);
        check("reset_busy", 32'(Tx_BUSY), 32'd0);
        check("reset_done", 32'(Tx_DONE), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Basic frame, then line returns idle.
        send(8'hA5, FR_A5);
        wait_done(n_done_exp);
        repeat (3) @(negedge clk);
        check("idle_txd_after_a5", 32'(TxD), 32'd1);
        check("idle_busy_after_a5", 32'(Tx_BUSY), 32'd0);

        // Odd-weight byte, parity bit set.
        send(8'h07, FR_07);
        wait_done(n_done_exp);

        // Write while busy.
        send(8'hA5, FR_A5);
        wait_frame_tick(40);
        check("busy_at_tick40", 32'(Tx_BUSY), 32'd1);
`ifdef UART_TX_HOLD_BUFFER_EN
        send(8'h3C, FR_3C);
`else
        do_write(8'h3C);
`endif
        wait_done(n_done_exp);
        repeat (900) @(negedge clk);
        check("done_count_after_busy_write", 32'(done_cnt), 32'(n_done_exp));

        // Reset mid-frame.
        do_write(8'hA5);
        wait_frame_tick(90);
        check("txd_low_before_reset", 32'(TxD), 32'd0);
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_abort_txd", 32'(TxD), 32'd1);
        check("reset_abort_busy", 32'(Tx_BUSY), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("reset_abort_no_done", 32'(done_cnt), 32'(d0));
        send(8'h55, FR_55);
        wait_done(n_done_exp);

        // Enable dropped mid-frame, then a write while disabled.
        do_write(8'h00);
        wait_frame_tick(60);
        check("txd_low_before_en_abort", 32'(TxD), 32'd0);
        d0 = done_cnt;
        @(negedge clk);
        Tx_EN = 1'b0;
        @(posedge clk);
        #1;
        check("en_abort_txd", 32'(TxD), 32'd1);
        check("en_abort_busy", 32'(Tx_BUSY), 32'd0);
        check("en_abort_done", 32'(Tx_DONE), 32'd0);
        s0 = rx_starts;
        do_write(8'h33);
        repeat (100) @(negedge clk);
        check("disabled_write_busy", 32'(Tx_BUSY), 32'd0);
        check("disabled_write_txd", 32'(TxD), 32'd1);
        check("disabled_write_no_start", 32'(rx_starts), 32'(s0));
        check("en_abort_no_done", 32'(done_cnt), 32'(d0));
        Tx_EN = 1'b1;
        repeat (8) @(negedge clk);

`ifdef UART_TX_HOLD_BUFFER_EN
        // Two writes in one frame go out back to back.
        send(8'h11, FR_11);
        wait_frame_tick(5);
        send(8'h22, FR_22);
        wait_done(n_done_exp);
        check("b2b_done_spacing", 32'(last_done_tick - prev_done_tick), 32'd176);
`endif

        repeat (20) @(negedge clk);
        check("leftover_expected", 32'(exp_q.size()), 32'd0);
        check("final_idle_busy", 32'(Tx_BUSY), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_data_transmission.md
Name: uart_tx_data_transmission

Overview:
- Transmit side of the UART link; the counterpart of the 16x-oversampling receiver.
- Accepts one data byte through a write handshake and frames it as an 11-bit packet: start, 8 data LSB-first, even parity, stop.
- Serialises the packet on TxD, holding each bit for OVERSAMPLE sample-enable ticks, so the far-end receiver's 16-tick majority vote stays aligned.
- Sits between the 7-segment/control logic and the physical TxD line; the baud/sample tick generator is external.

Parameters:
- DATA_W, 8, payload bits per packet.
- OVERSAMPLE, 16, sample-enable ticks per transmitted bit.
- PACKET_W, DATA_W+3, packet length (start + data + parity + stop).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- Tx_EN  in  1  transmitter enable; low = idle line, frame aborted.
- Tx_sample_ENABLE  in  1  one-clk-wide tick at 16x baud.
- Tx_WR  in  1  write strobe; Tx_DATA captured when accepted.
- Tx_DATA  in  DATA_W  byte to send.
- TxD  out  1  serial line; idle high.
- Tx_BUSY  out  1  high while a frame is loaded or being shifted.
- Tx_DONE  out  1  one-clk pulse when the stop bit completes.

Behaviour:
- Reset values: TxD=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, tick_cnt=0, bit_idx=0, shift register cleared.
- Packet build at accept, bit 0 first:
  - bit0 = 0 (start).
  - bits1..8 = Tx_DATA[0..7].
  - bit9 = XOR of Tx_DATA (even parity).
  - bit10 = 1 (stop).
- Accept rule: Tx_WR && Tx_EN && !Tx_BUSY.
  - Packet is latched and state goes to WAIT_TICK on the same edge.
  - Tx_BUSY rises on that edge (1-cycle latency).
  - Tx_WR while busy is ignored (see optional feature).
- State machine:
  - IDLE -> WAIT_TICK on accept.
  - WAIT_TICK -> SEND on the first Tx_sample_ENABLE after accept. TxD drives bit0 on that edge; tick_cnt=1.
  - SEND, per tick:
    - tick_cnt < OVERSAMPLE: increment tick_cnt.
    - tick_cnt == OVERSAMPLE and bit_idx < PACKET_W-1: bit_idx+1, TxD=next bit, tick_cnt=1.
    - tick_cnt == OVERSAMPLE and bit_idx == PACKET_W-1: go to IDLE, TxD=1, Tx_BUSY=0, Tx_DONE=1 for one clk.
- Frame duration: exactly PACKET_W*OVERSAMPLE = 176 ticks from start-bit edge to return to IDLE.
- Clock cycles between ticks do not change TxD.
- Tx_EN low in any state: next edge forces IDLE, TxD=1, Tx_BUSY=0. No Tx_DONE. Partial frame is dropped.
- Reset mid-frame: same as the Tx_EN abort. Reset takes priority over every other input.
- Tx_WR coincident with the final stop tick: ignored, because Tx_BUSY is still 1 that cycle.
- Counter widths: tick_cnt is $clog2(OVERSAMPLE+1); bit_idx is $clog2(PACKET_W). No wrap beyond the terminal values.

Optional Feature:
- Macro: UART_TX_HOLD_BUFFER_EN.
- With the macro defined:
  - A one-entry holding register is added.
  - Tx_WR while Tx_BUSY=1 and the hold register is empty is accepted into the hold register.
  - On the stop-bit final tick, the held packet moves straight to SEND: TxD=0 on the same edge, Tx_BUSY stays 1, Tx_DONE still pulses. There is no idle gap.
  - Tx_WR while the hold register is full is ignored.
  - Abort/reset also clears the hold register.
- Without the macro: single packet only; Tx_BUSY gating as above.

Decomposition:
- Shared package uart_pkg:
  - tx_state_t enum {IDLE, WAIT_TICK, SEND}.
  - START_BIT=1'b0, STOP_BIT=1'b1.
  - Function build_packet(data) returning PACKET_W bits with parity.
- Sub-module tx_bit_timer:
  - Counts Tx_sample_ENABLE ticks.
  - Emits bit_end at OVERSAMPLE.
  - Has sync clear.

Test Plan:
- Send 8'hA5, ticks every 4 clk:
  - TxD sequence 0,1,0,1,0,0,1,0,1,0,1, each held 16 ticks.
  - Tx_BUSY high 176 ticks.
  - Tx_DONE one pulse, then TxD=1.
- Send 8'h07 (odd weight): parity bit=1. Capture on a model 16x receiver and compare the byte.
- Tx_WR 8'h3C at tick 40 of an 8'hA5 frame, macro off: 8'h3C is never sent; only one Tx_DONE.
- reset=1 at tick 90 of a frame: TxD=1 and Tx_BUSY=0 on the next edge. A new write 8'h55 afterwards sends a clean frame.
- Tx_EN low at tick 60: TxD=1 next edge, no Tx_DONE. Tx_WR with Tx_EN=0 produces no start bit.
- Macro on: writes 8'h11 then 8'h22 during the first frame. Result is two back-to-back frames, the stop bit directly followed by the start bit, and two Tx_DONE pulses 176 ticks apart.
